prog_timer: RTL and testbench

PROG_TIMER -- requirements
Module: prog_timer

---
 rtl/prog_timer.sv | 90 +++++++++
 tb/tb_prog_timer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/prog_timer.sv
// Programmable down-counting timer with prescaler, periodic or one-shot mode.
// Emits a registered single-cycle tick at each terminal count.
module prog_timer #(
    parameter int WIDTH = 20,
    parameter int PW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic [PW-1:0]    presc,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] period_l, cnt, cnt_n;
    logic [PW-1:0]    presc_l, pcnt, pcnt_n;
    logic             mode_l;
    logic             tick_n;
    logic             load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pcnt     <= '0;
            period_l <= '0;
            presc_l  <= '0;
            mode_l   <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pcnt  <= pcnt_n;
            tick  <= tick_n;
            if (load) begin
                period_l <= period;
                presc_l  <= presc;
                mode_l   <= mode;
            end
        end
    end

    // stop beats start, start beats counting; tick is low unless a terminal step occurs
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pcnt_n  = pcnt;
        tick_n  = 1'b0;
        load    = 1'b0;
        if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
            pcnt_n  = '0;
        end else if (start) begin
            load    = 1'b1;
            cnt_n   = period;
            pcnt_n  = '0;
            state_n = RUN;
        end else if (state == RUN && en) begin
            if (pcnt == presc_l) begin
                pcnt_n = '0;
                if (cnt != '0) begin
                    cnt_n = cnt - WIDTH'(1);
                end else begin
                    tick_n = 1'b1;
                    if (mode_l)
                        state_n = DONE;
                    else
                        cnt_n = period_l;
                end
            end else begin
                pcnt_n = pcnt + PW'(1);
            end
        end
    end

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign count = cnt;

endmodule

// File: tb/tb_prog_timer.sv
// Directed self-checking bench for prog_timer: periodic, one-shot, enable
// gating, start/stop collisions, async reset and width boundaries.
module tb_prog_timer;

    localparam int WIDTH = 20;
    localparam int PW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en, start, stop, mode;
    logic [WIDTH-1:0] period;
    logic [PW-1:0]    presc;
    logic             tick, busy, done;
    logic [WIDTH-1:0] count;

    int checks = 0;
    int errors = 0;

    prog_timer #(.WIDTH(WIDTH), .PW(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
        .mode(mode), .period(period), .presc(presc),
        .tick(tick), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic t, input logic b,
                           input logic d, input logic [WIDTH-1:0] c);
        chk({tag, ".tick"},  32'(tick),  32'(t));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".count"}, 32'(count), 32'(c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        period = '0; presc = '0;
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b0, '0);
        step(); step();
        rst = 1'b0;
        step();
        chk_all("idle_after_reset", 1'b0, 1'b0, 1'b0, '0);

        // periodic, period=3 presc=0
        en = 1'b1; period = 3; presc = 0; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("per.load", 1'b0, 1'b1, 1'b0, 3);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("per.count", 32'(count), 32'((3 - (i % 4) + 4) % 4));
            chk("per.tick",  32'(tick),  32'((i % 4) == 0));
        end

        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all("stop", 1'b0, 1'b0, 1'b0, 0);

        // prescaled one-shot: period=2 presc=1
        period = 2; presc = 1; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("os.load", 1'b0, 1'b1, 1'b0, 2);
        begin
            logic [WIDTH-1:0] exp_c [1:6] = '{2, 1, 1, 0, 0, 0};
            for (int i = 1; i <= 5; i++) begin
                step();
                chk_all("os.run", 1'b0, 1'b1, 1'b0, exp_c[i]);
            end
            step();
            chk_all("os.term", 1'b1, 1'b0, 1'b1, exp_c[6]);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("os.done_hold", 1'b0, 1'b0, 1'b1, 0);
        end

        // enable gating: en low for 5 cycles delays first tick by 5
        period = 3; presc = 0; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk_all("en.e1", 1'b0, 1'b1, 1'b0, 2);
        step();
        chk_all("en.e2", 1'b0, 1'b1, 1'b0, 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("en.frozen", 1'b0, 1'b1, 1'b0, 1);
        end
        en = 1'b1;
        step();
        chk_all("en.e3", 1'b0, 1'b1, 1'b0, 0);
        step();
        chk_all("en.e4_tick", 1'b1, 1'b1, 1'b0, 3);

        // start and stop on the same edge: stop wins
        start = 1'b1; stop = 1'b1; period = 7;
        step();
        start = 1'b0; stop = 1'b0;
        chk_all("startstop", 1'b0, 1'b0, 1'b0, 0);

        // start on a terminal edge: restart, no tick
        period = 1; presc = 0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk_all("term.c0", 1'b0, 1'b1, 1'b0, 0);
        period = 5; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("term.restart", 1'b0, 1'b1, 1'b0, 5);

        // async reset during run at count=2
        period = 3; presc = 0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("ar.pre_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk_all("ar.async", 1'b0, 1'b0, 1'b0, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_all("ar.idle", 1'b0, 1'b0, 1'b0, 0);
        end

        // period=0 presc=0 periodic: tick every cycle
        period = 0; presc = 0; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("p0.load", 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("p0.tick", 1'b1, 1'b1, 1'b0, 0);
        end

        // maximum period and prescaler
        period = '1; presc = '1; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("max.load", 1'b0, 1'b1, 1'b0, 20'hFFFFF);
        repeat (255) step();
        chk_all("max.presc_hold", 1'b0, 1'b1, 1'b0, 20'hFFFFF);
        step();
        chk_all("max.step1", 1'b0, 1'b1, 1'b0, 20'hFFFFE);
        repeat (256) step();
        chk_all("max.step2", 1'b0, 1'b1, 1'b0, 20'hFFFFD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
